// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared definitions for the multi-channel LED driver.
//               Mode encodings used by the write port and the per-channel
//               output function.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef logic [1:0] led_mode_t;

    localparam led_mode_t MODE_OFF   = 2'd0;
    localparam led_mode_t MODE_ON    = 2'd1;
    localparam led_mode_t MODE_BLINK = 2'd2;
    localparam led_mode_t MODE_PWM   = 2'd3;

endpackage : led_pkg
`default_nettype wire

// File: rtl/divisor_tick.sv
`default_nettype none
// ============================================================================
// Module      : divisor_tick
// Description : Free-running prescaler. Counts 0..PRESCALE-1 and raises tick
//               for the single cycle in which the count sits at PRESCALE-1,
//               giving one pulse every PRESCALE clock cycles.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               tick  - one-cycle pulse at each prescaler wrap
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_tick #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                 c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

    // Decoded straight from the count so the pulse lines up with the wrap
    // cycle; the count resets to 0, so tick is low during reset.
    assign tick = (r_count == c_last);

endmodule : divisor_tick
`default_nettype wire

// File: rtl/controlador_leds_pwm.sv
`default_nettype none
// ============================================================================
// Module      : controlador_leds_pwm
// Description : Multi-channel LED driver. Each channel is configured through
//               a write port as OFF, ON, BLINK (toggles at the prescaled tick
//               rate) or PWM (brightness from a duty value compared against a
//               shared free-running counter). LED outputs are registered.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               wr_en   - write strobe
//               wr_chan - channel to configure (out-of-range ignored)
//               wr_mode - 0=OFF 1=ON 2=BLINK 3=PWM
//               wr_duty - PWM duty value (stored in every mode)
//               leds    - registered LED drive, bit i = channel i
//               tick    - one-cycle pulse at each prescaler wrap
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_leds_pwm
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PRESCALE = 50_000_000,
    parameter int DUTY_W   = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              wr_en,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] wr_chan,
    input  led_mode_t                                         wr_mode,
    input  logic [DUTY_W-1:0]                                 wr_duty,
    output logic [NUM_LEDS-1:0]                               leds,
    output logic                                              tick
);

    localparam int                c_chan_w = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [DUTY_W-1:0] c_pwm_one = DUTY_W'(1);

    logic              w_tick;
    logic [DUTY_W-1:0] r_pwm_cnt;

    divisor_tick #(
        .PRESCALE (PRESCALE)
    ) u_divisor_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign tick = w_tick;

    // Shared PWM counter keeps every PWM channel phase-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + c_pwm_one;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        localparam logic [c_chan_w-1:0] c_idx = c_chan_w'(i);

        led_mode_t         r_mode;
        logic [DUTY_W-1:0] r_duty;
        logic              r_phase;
        logic              r_led;
        logic              w_sel;
        logic              w_out;

        // Only indices 0..NUM_LEDS-1 are decoded, so an out-of-range
        // wr_chan selects no channel and the write is dropped.
        assign w_sel = wr_en && (wr_chan == c_idx);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mode <= MODE_OFF;
                r_duty <= '0;
            end else if (w_sel) begin
                r_mode <= wr_mode;
                r_duty <= wr_duty;
            end
        end

        // A BLINK write restarts the phase lit and overrides a tick on the
        // same edge; otherwise the phase toggles on ticks while blinking.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_phase <= 1'b0;
            end else if (w_sel && (wr_mode == MODE_BLINK)) begin
                r_phase <= 1'b1;
            end else if (w_tick && (r_mode == MODE_BLINK)) begin
                r_phase <= ~r_phase;
            end
        end

        always_comb begin
            w_out = 1'b0;
            case (r_mode)
                MODE_OFF:   w_out = 1'b0;
                MODE_ON:    w_out = 1'b1;
                MODE_BLINK: w_out = r_phase;
                MODE_PWM:   w_out = (r_pwm_cnt < r_duty);
                default:    w_out = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_led <= 1'b0;
            end else begin
                r_led <= w_out;
            end
        end

        assign leds[i] = r_led;
    end

endmodule : controlador_leds_pwm
`default_nettype wire

// File: tb/tb_controlador_leds_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_leds_pwm
// Description : Self-checking bench for controlador_leds_pwm. Five channels
//               (3-bit channel index, so indices 5..7 are out of range),
//               PRESCALE=4, DUTY_W=4. A cycle-count based reference model
//               predicts leds and tick; directed literal checks pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_leds_pwm;
    import led_pkg::*;

    localparam int NL  = 5;
    localparam int P   = 4;
    localparam int DW  = 4;
    localparam int CW  = 3;
    localparam int PER = 1 << DW;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [CW-1:0] wr_chan = '0;
    led_mode_t     wr_mode = MODE_OFF;
    logic [DW-1:0] wr_duty = '0;
    logic [NL-1:0] leds;
    logic          tick;

    controlador_leds_pwm #(
        .NUM_LEDS (NL),
        .PRESCALE (P),
        .DUTY_W   (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_chan (wr_chan),
        .wr_mode (wr_mode),
        .wr_duty (wr_duty),
        .leds    (leds),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the prescaler and PWM counter are just the number of
    // rising edges since reset release taken modulo their periods.
    int            m_mode [NL];
    int            m_duty [NL];
    bit            m_phase[NL];
    logic [NL-1:0] m_leds  = '0;
    int            m_edges = 0;

    always @(posedge clk or negedge rst_n) begin
        int pwm;
        bit t;
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) begin
                m_mode[i]  = 0;
                m_duty[i]  = 0;
                m_phase[i] = 0;
            end
            m_leds  = '0;
            m_edges = 0;
        end else begin
            pwm = m_edges % PER;
            t   = (m_edges % P) == P - 1;
            for (int i = 0; i < NL; i++) begin
                case (m_mode[i])
                    0:       m_leds[i] = 1'b0;
                    1:       m_leds[i] = 1'b1;
                    2:       m_leds[i] = m_phase[i];
                    default: m_leds[i] = (pwm < m_duty[i]);
                endcase
                if (m_mode[i] == 2 && t) m_phase[i] = !m_phase[i];
            end
            if (wr_en && int'(wr_chan) < NL) begin
                m_mode[int'(wr_chan)] = int'(wr_mode);
                m_duty[int'(wr_chan)] = int'(wr_duty);
                if (wr_mode == MODE_BLINK) m_phase[int'(wr_chan)] = 1'b1;
            end
            m_edges++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_leds", leds, m_leds);
        chk("model_tick", tick, ((m_edges % P) == P - 1) ? 1 : 0);
    end

    // Called just after a falling edge; the write is sampled on the next
    // rising edge and the task returns on the falling edge after it.
    task automatic wr(input int ch, input int md, input int du);
        wr_en   = 1'b1;
        wr_chan = CW'(ch);
        wr_mode = 2'(md);
        wr_duty = DW'(du);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic count_high(input int ch, output int hi);
        hi = 0;
        for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            hi += int'(leds[ch]);
        end
    endtask

    task automatic random_phase(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            if ($urandom_range(0, 3) == 0)
                wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, PER - 1));
            else
                @(negedge clk);
        end
    endtask

    initial begin
        int  hi;
        bit  found;

        // Reset held for five cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_leds", leds, 0);
            chk("rst_tick", tick, 0);
        end
        rst_n = 1'b1;

        // First tick in the fourth cycle after release, then every four.
        @(negedge clk); chk("tick_c1", tick, 0);
        @(negedge clk); chk("tick_c2", tick, 0);
        @(negedge clk); chk("tick_first", tick, 1);
        @(negedge clk); chk("tick_c4", tick, 0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("tick_second", tick, 1);

        // ON write.
        wr(2, 1, 0);
        @(negedge clk);
        chk("on_ch2", leds, 5'b00100);

        // BLINK: starts lit, 50% duty over 16 cycles.
        wr(0, 2, 0);
        @(negedge clk);
        chk("blink_start", leds[0], 1);
        count_high(0, hi);
        chk("blink_duty", hi, 8);

        // Write on a tick edge while lit: write wins, phase stays 1.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (tick && leds[0]) found = 1;
        end
        chk("blink_tick_seen", found, 1);
        wr(0, 2, 0);
        @(negedge clk);
        chk("write_wins", leds[0], 1);

        // PWM duty values.
        wr(1, 3, 4);
        @(negedge clk);
        count_high(1, hi);
        chk("pwm_duty4", hi, 4);
        wr(1, 3, 0);
        @(negedge clk);
        count_high(1, hi);
        chk("pwm_duty0", hi, 0);
        wr(1, 3, 15);
        @(negedge clk);
        count_high(1, hi);
        chk("pwm_duty15", hi, 15);

        // Out-of-range channels.
        wr(5, 1, 3);
        wr(6, 1, 3);
        wr(7, 3, 9);
        @(negedge clk);
        chk("illegal_ch4", leds[4], 0);
        chk("illegal_ch2_on", leds[2], 1);

        random_phase(400);

        // Asynchronous reset between edges while a channel is lit.
        wr(2, 1, 0);
        @(negedge clk);
        chk("pre_rst_lit", leds[2], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_leds", leds, 0);
        chk("async_tick", tick, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_off", leds, 0);
        end

        random_phase(200);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_controlador_leds_pwm
`default_nettype wire

// File: doc/controlador_leds_pwm.md
Name: controlador_leds_pwm

Overview:
Multi-channel LED driver for the board LEDs with a built-in prescaler.
- Each channel is configured at run time through a simple write port.
- Modes per channel: OFF, ON, BLINK (toggle at the prescaled tick rate) or PWM (brightness set by a duty value).
- Sits between the user logic or switch decoder and the LED pins.
- Replaces per-LED on/off modules fed by a separate clock divider.

Parameters:
- NUM_LEDS, 4: number of LED channels (1..16).
- PRESCALE, 50_000_000: clk cycles per blink tick (>= 2).
- DUTY_W, 8: width of the PWM duty value and of the PWM counter (1..16).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe, sampled on the rising edge of clk.
- wr_chan  in  max(1,$clog2(NUM_LEDS))  channel index to configure.
- wr_mode  in  2  mode encoding: 0=OFF, 1=ON, 2=BLINK, 3=PWM.
- wr_duty  in  DUTY_W  PWM duty value.
- leds  out  NUM_LEDS  registered LED drive; bit i belongs to channel i.
- tick  out  1  one-cycle pulse at each prescaler wrap.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock edge needed):
  - all modes = OFF, duties = 0, blink phases = 0;
  - prescaler and PWM counters = 0;
  - leds = 0, tick = 0.
- Prescaler:
  - count runs 0..PRESCALE-1, then wraps to 0;
  - tick = 1 for exactly the cycle in which count == PRESCALE-1;
  - period is exactly PRESCALE cycles; first tick comes PRESCALE cycles after reset release.
- PWM counter:
  - free-running, DUTY_W bits, +1 every clk, wraps from 2^DUTY_W-1 to 0;
  - shared by all channels, so all PWM channels are phase-aligned.
- Write port:
  - on an edge with wr_en=1 and wr_chan < NUM_LEDS, that channel's mode <= wr_mode and duty <= wr_duty;
  - duty is stored whatever the mode;
  - wr_chan >= NUM_LEDS: write ignored, no state changes.
- Blink phase (per channel, 1 bit):
  - set to 1 by a write with wr_mode=BLINK, so the LED starts lit;
  - otherwise toggles on every edge where tick=1 while the channel mode is BLINK;
  - write and tick on the same edge: the write wins (phase = 1).
- Channel output function:
  - OFF -> 0; ON -> 1; BLINK -> phase;
  - PWM -> (pwm_cnt < duty), unsigned compare: duty=0 is always dark, duty=2^DUTY_W-1 is dark 1 cycle per period.
- Latency: leds is a register of the output function.
  - A write sampled on edge k is visible on leds after edge k+1.
  - A tick at edge k changes a blinking LED after edge k+1.
- Mode change mid-blink or mid-PWM takes effect with the same 1-cycle latency; no glitch wait and no period completion.
- Async reset mid-operation: leds forced to 0 immediately; the block restarts in the all-OFF state after rst_n rises.

Decomposition:
- Package led_pkg:
  - localparams MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_PWM=2'd3;
  - mode typedef, 2 bits.
- One sub-module: divisor_tick (PRESCALE parameter; ports clk, rst_n, tick).
- Per-channel registers and output logic are generated in a for-generate loop in the top level.

Test Plan (NUM_LEDS=4, PRESCALE=4, DUTY_W=4 unless stated):
1. Reset: hold rst_n=0 for 5 cycles -> leds=4'b0000 and tick=0 throughout; after release, first tick on cycle 4, then one every 4 cycles.
2. ON write: write ch2 mode=1 at edge k -> leds=4'b0100 from edge k+1; other bits stay 0.
3. BLINK: write ch0 mode=2 -> leds[0]=1 one cycle later, then inverts one cycle after each tick (every 4 cycles, 50% duty). Also write again on a tick edge -> phase=1 (write wins).
4. PWM: ch1 mode=3 with duty=4 -> leds[1] high exactly 4 of every 16 cycles. duty=0 -> always 0. duty=15 -> low exactly 1 of 16 cycles.
5. Illegal channel: wr_chan=3'd5 with NUM_LEDS=4 (wr_chan 3 bits via NUM_LEDS=5 build, or index out of range) -> no change on any leds bit.
6. Async reset: assert rst_n=0 between clock edges during BLINK/PWM activity -> leds=0 immediately, without a clock edge. After release, all channels stay OFF until rewritten.
